pulse_detector: RTL and testbench
=================================

PULSE_DETECTOR -- requirements
Module: pulse_detector

Interface
REQ-001 SHALL have parameter DWIDTH, default 14, sample width; must match the downsampler DWIDTH.
REQ-002 SHALL have parameter WIDTH_BITS, default 16, width of the pulse-length field.
REQ-003 SHALL have parameter MIN_WIDTH, default 2, minimum pulse length in samples for an event to be reported.
REQ-004 SHALL have port CLOCK_IN  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ENABLE  input  1  sample qualifier; a sample is consumed only on cycles with ENABLE=1.
REQ-007 SHALL have port DATA_IN  input  DWIDTH  unsigned downsampled detector amplitude.
REQ-008 SHALL have port THRESHOLD  input  DWIDTH  unsigned pulse-start level.
REQ-009 SHALL have port HYSTERESIS  input  DWIDTH  unsigned; the pulse-end level is THRESHOLD-HYSTERESIS.
REQ-010 SHALL have port EVT_VALID  output  1  event record available.
REQ-011 SHALL have port EVT_READY  input  1  consumer accepts the record.
REQ-012 SHALL have port EVT_PEAK  output  DWIDTH  maximum sample within the pulse.
REQ-013 SHALL have port EVT_WIDTH  output  WIDTH_BITS  pulse length in consumed samples.
REQ-014 SHALL have port EVT_AREA  output  DWIDTH+WIDTH_BITS  sum of pulse samples (see Configuration).
REQ-015 SHALL have port DROP_CNT  output  16  count of qualified events lost to backpressure.

Function
REQ-016 SHALL implement FSM IDLE/PULSE; only cycles with ENABLE=1 advance the FSM or its accumulators.
REQ-017 SHALL transition IDLE->PULSE on a consumed sample with DATA_IN>=THRESHOLD; that sample initialises peak=DATA_IN, width=1, area=DATA_IN.
REQ-018 SHALL stay in PULSE while DATA_IN>=end level, updating peak=max, width+=1 (saturating at all-ones), area+=DATA_IN (saturating).
REQ-019 SHALL compute end level as THRESHOLD-HYSTERESIS clamped to 0 when HYSTERESIS>THRESHOLD; with end level 0, a pulse never ends (intended).
REQ-020 SHALL transition PULSE->IDLE on a consumed sample with DATA_IN<end level; that sample is not included in the record.
REQ-021 SHALL qualify the pulse on end when width>=MIN_WIDTH; shorter pulses are discarded silently, with no DROP_CNT increment.
REQ-022 SHALL load a qualified record into the output holding register and assert EVT_VALID on the clock edge after the ending sample (latency 1).
REQ-023 SHALL hold EVT_VALID and all EVT_* fields stable until EVT_VALID&&EVT_READY; EVT_VALID clears on that edge.
REQ-024 SHALL, when a qualified record completes while the register is full and not being handed off that cycle, discard the new record and increment DROP_CNT (saturating at 65535).
REQ-025 SHALL, on simultaneous handoff (EVT_VALID&&EVT_READY) and a new qualified record, load the new record and keep EVT_VALID=1.
REQ-026 SHALL sample THRESHOLD/HYSTERESIS every consumed sample; changes mid-pulse take effect on the next sample.
REQ-027 SHALL keep the handshake operating while ENABLE=0.

Reset
REQ-028 SHALL, on RESET_N low, immediately force state=IDLE, EVT_VALID=0, EVT_PEAK=0, EVT_WIDTH=0, EVT_AREA=0, DROP_CNT=0, and accumulators=0; a pulse in progress is abandoned with no record emitted.
REQ-029 SHALL deassert reset synchronously to CLOCK_IN by the integrating top; the block adds no synchroniser.

Configuration
REQ-030 SHALL compile area accumulation only when macro PULSE_DETECTOR_AREA_EN is defined; without it, EVT_AREA is tied to 0, no accumulator is synthesised, and all other behaviour is unchanged.

Structure
REQ-031 SHALL place the FSM state enum, DROP_CNT width (16), and default DWIDTH/WIDTH_BITS constants in shared package citometer_pkg.
REQ-032 SHALL use one sub-module sat_counter (parameterised width, increment enable, synchronous clear, saturating) for the width and DROP_CNT counters.

Verification
REQ-033 SHALL cover this scenario: THRESHOLD=1000, HYST=100, samples 0,1200,1500,1300,850 with EVT_READY=1 -> one record PEAK=1500, WIDTH=3, AREA=4000, valid one cycle after 850.
REQ-034 SHALL cover this scenario: MIN_WIDTH=2, samples 0,1200,500 -> no EVT_VALID, DROP_CNT=0.
REQ-035 SHALL cover this scenario: EVT_READY=0, two qualified pulses -> first record held unchanged, DROP_CNT=1; then EVT_READY=1 -> first record accepted.
REQ-036 SHALL cover this scenario: hysteresis with samples 1200,950,920,1100,800 (THR=1000, HYST=100) -> single record WIDTH=4, PEAK=1200.
REQ-037 SHALL cover this scenario: RESET_N low mid-pulse -> outputs zero immediately, no record after release; ENABLE=0 gaps inside a pulse -> WIDTH counts only enabled samples.
REQ-038 SHALL cover this scenario: HYSTERESIS=2000 > THRESHOLD=1000 -> end level clamps to 0, and the pulse never ends.

Source files
------------

// File: rtl/citometer_pkg.sv
// ============================================================================
// Module      : citometer_pkg
// Description : Shared constants and the pulse FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package citometer_pkg;

  localparam int DEFAULT_DWIDTH     = 14;
  localparam int DEFAULT_WIDTH_BITS = 16;
  localparam int DROP_CNT_W         = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import citometer_pkg::*;
#(
  parameter int W = DROP_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear applies first, so clr_i together with inc_i restarts the count at 1.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (inc_i && !(&cnt_d)) begin
      cnt_d = cnt_d + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pulse_detector.sv
// ============================================================================
// Module      : pulse_detector
// Description : Threshold/hysteresis pulse detector emitting peak/width/area
//               records; area accumulation only with PULSE_DETECTOR_AREA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_detector
  import citometer_pkg::*;
#(
  parameter int DWIDTH     = DEFAULT_DWIDTH,
  parameter int WIDTH_BITS = DEFAULT_WIDTH_BITS,
  parameter int MIN_WIDTH  = 2
) (
  input  logic                         CLOCK_IN,
  input  logic                         RESET_N,
  input  logic                         ENABLE,
  input  logic [DWIDTH-1:0]            DATA_IN,
  input  logic [DWIDTH-1:0]            THRESHOLD,
  input  logic [DWIDTH-1:0]            HYSTERESIS,
  output logic                         EVT_VALID,
  input  logic                         EVT_READY,
  output logic [DWIDTH-1:0]            EVT_PEAK,
  output logic [WIDTH_BITS-1:0]        EVT_WIDTH,
  output logic [DWIDTH+WIDTH_BITS-1:0] EVT_AREA,
  output logic [DROP_CNT_W-1:0]        DROP_CNT
);

  localparam int AW = DWIDTH + WIDTH_BITS;

  state_e                state_q;
  logic [DWIDTH-1:0]     peak_q;
  logic [DWIDTH-1:0]     peak_d;
  logic [WIDTH_BITS-1:0] width_q;
  logic                  evt_valid_q;
  logic [DWIDTH-1:0]     evt_peak_q;
  logic [WIDTH_BITS-1:0] evt_width_q;

  logic [DWIDTH-1:0] w_end_level;
  logic              w_start;
  logic              w_stay;
  logic              w_end;
  logic              w_qual;
  logic              w_fire;
  logic              w_load;
  logic              w_drop;

  assign w_end_level = (HYSTERESIS > THRESHOLD) ? '0 : (THRESHOLD - HYSTERESIS);
  assign w_start = ENABLE && (state_q == ST_IDLE)  && (DATA_IN >= THRESHOLD);
  assign w_stay  = ENABLE && (state_q == ST_PULSE) && (DATA_IN >= w_end_level);
  assign w_end   = ENABLE && (state_q == ST_PULSE) && (DATA_IN <  w_end_level);
  assign w_qual  = w_end && (width_q >= WIDTH_BITS'(MIN_WIDTH));
  assign w_fire  = evt_valid_q && EVT_READY;
  // A completed record may take the slot if it is empty or being vacated this edge.
  assign w_load  = w_qual && (!evt_valid_q || EVT_READY);
  assign w_drop  = w_qual && evt_valid_q && !EVT_READY;

  always_comb begin
    peak_d = peak_q;
    if (w_start || (w_stay && (DATA_IN > peak_q))) begin
      peak_d = DATA_IN;
    end
  end

  sat_counter #(.W(WIDTH_BITS)) u_width_cnt (
    .clk_i  (CLOCK_IN),
    .rst_ni (RESET_N),
    .clr_i  (w_start),
    .inc_i  (w_start || w_stay),
    .cnt_o  (width_q)
  );

  sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk_i  (CLOCK_IN),
    .rst_ni (RESET_N),
    .clr_i  (1'b0),
    .inc_i  (w_drop),
    .cnt_o  (DROP_CNT)
  );

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      peak_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_peak_q  <= '0;
      evt_width_q <= '0;
    end else begin
      if (w_start) begin
        state_q <= ST_PULSE;
      end else if (w_end) begin
        state_q <= ST_IDLE;
      end
      peak_q <= peak_d;
      if (w_load) begin
        evt_valid_q <= 1'b1;
        evt_peak_q  <= peak_q;
        evt_width_q <= width_q;
      end else if (w_fire) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

`ifdef PULSE_DETECTOR_AREA_EN
  logic [AW-1:0] area_q;
  logic [AW-1:0] area_d;
  logic [AW-1:0] evt_area_q;
  logic [AW:0]   w_area_sum;

  assign w_area_sum = {1'b0, area_q} + {{(AW+1-DWIDTH){1'b0}}, DATA_IN};

  always_comb begin
    area_d = area_q;
    if (w_start) begin
      area_d = {{(AW-DWIDTH){1'b0}}, DATA_IN};
    end else if (w_stay) begin
      area_d = w_area_sum[AW] ? '1 : w_area_sum[AW-1:0];
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      area_q     <= '0;
      evt_area_q <= '0;
    end else begin
      area_q <= area_d;
      if (w_load) begin
        evt_area_q <= area_q;
      end
    end
  end

  assign EVT_AREA = evt_area_q;
`else
  assign EVT_AREA = '0;
`endif

  assign EVT_VALID = evt_valid_q;
  assign EVT_PEAK  = evt_peak_q;
  assign EVT_WIDTH = evt_width_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_detector.sv
// ============================================================================
// Module      : tb_pulse_detector
// Description : Scoreboard bench for pulse_detector with a sample-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_detector;

  localparam int MIN_W = 2;

  typedef struct {
    longint peak;
    longint width;
    longint area;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [13:0] data;
  logic [13:0] thr;
  logic [13:0] hyst;
  logic        evt_valid;
  logic        evt_ready;
  logic [13:0] evt_peak;
  logic [15:0] evt_width;
  logic [29:0] evt_area;
  logic [15:0] drop_cnt;

  pulse_detector #(.DWIDTH(14), .WIDTH_BITS(16), .MIN_WIDTH(MIN_W)) dut (
    .CLOCK_IN   (clk),
    .RESET_N    (rst_n),
    .ENABLE     (en),
    .DATA_IN    (data),
    .THRESHOLD  (thr),
    .HYSTERESIS (hyst),
    .EVT_VALID  (evt_valid),
    .EVT_READY  (evt_ready),
    .EVT_PEAK   (evt_peak),
    .EVT_WIDTH  (evt_width),
    .EVT_AREA   (evt_area),
    .DROP_CNT   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  rec_t   exp_q[$];
  int     samples[$];
  bit     in_pulse = 0;
  bit     m_full = 0;
  bit     m_full_now = 0;
  longint m_drop = 0;
  longint m_drop_now = 0;
  int     thr_v = 1000;
  int     hyst_v = 100;

  int s1[5] = '{0, 1200, 1500, 1300, 850};
  int s2[3] = '{0, 1200, 500};
  int s3[9] = '{1200, 1300, 0, 1500, 1600, 1700, 0, 0, 0};
  int s4[6] = '{0, 1200, 950, 920, 1100, 800};
  int s5[8] = '{1200, 1400, 0, 1300, 1300, 0, 1500, 1600};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t make_rec();
    rec_t   r;
    longint sum = 0;
    longint pk = 0;
    foreach (samples[i]) begin
      sum += samples[i];
      if (samples[i] > pk) pk = samples[i];
    end
    r.peak  = pk;
    r.width = (samples.size() > 65535) ? 65535 : samples.size();
`ifdef PULSE_DETECTOR_AREA_EN
    r.area  = (sum > ((64'd1 << 30) - 1)) ? ((64'd1 << 30) - 1) : sum;
`else
    r.area  = 0;
`endif
    return r;
  endfunction

  task automatic model_step(input bit e, input int d, input bit rdy);
    int endlvl;
    m_full_now = m_full;
    m_drop_now = m_drop;
    if (m_full && rdy) m_full = 0;
    if (e) begin
      endlvl = (hyst_v > thr_v) ? 0 : thr_v - hyst_v;
      if (!in_pulse) begin
        if (d >= thr_v) begin
          in_pulse = 1;
          samples.delete();
          samples.push_back(d);
        end
      end else if (d >= endlvl) begin
        samples.push_back(d);
      end else begin
        in_pulse = 0;
        if (samples.size() >= MIN_W) begin
          if (!m_full) begin
            exp_q.push_back(make_rec());
            m_full = 1;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
        samples.delete();
      end
    end
  endtask

  task automatic issue(input bit e, input int d, input bit rdy);
    @(posedge clk);
    #1;
    en        = e;
    data      = 14'(d);
    evt_ready = rdy;
    thr       = 14'(thr_v);
    hyst      = 14'(hyst_v);
    model_step(e, d, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1, 0, 1);
  endtask

  task automatic reset_mid_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_valid", evt_valid, 0);
    chk("reset_peak", evt_peak, 0);
    chk("reset_width", evt_width, 0);
    chk("reset_area", evt_area, 0);
    chk("reset_drop", drop_cnt, 0);
    exp_q.delete();
    samples.delete();
    in_pulse   = 0;
    m_full     = 0;
    m_full_now = 0;
    m_drop     = 0;
    m_drop_now = 0;
    repeat (2) @(posedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the model every cycle and pops on handoff.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      chk("evt_valid", evt_valid, m_full_now);
      chk("drop_cnt", drop_cnt, m_drop_now);
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 1, 0);
        end else begin
          r = exp_q[0];
          chk("evt_peak", evt_peak, r.peak);
          chk("evt_width", evt_width, r.width);
          chk("evt_area", evt_area, r.area);
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    data      = '0;
    evt_ready = 1'b0;
    thr       = 14'(thr_v);
    hyst      = 14'(hyst_v);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic record
    foreach (s1[i]) issue(1, s1[i], 1);
    idle(3);
    // Too-short pulse discarded
    foreach (s2[i]) issue(1, s2[i], 1);
    idle(3);
    // Backpressure: second record dropped, first held
    foreach (s3[i]) issue(1, s3[i], 0);
    #2;
    chk("drop_after_backpressure", drop_cnt, 1);
    issue(0, 0, 1);
    issue(0, 0, 1);
    idle(2);
    // Hysteresis keeps the pulse alive through the dips
    foreach (s4[i]) issue(1, s4[i], 1);
    idle(3);
    // ENABLE gaps inside a pulse
    issue(1, 1200, 1);
    issue(0, 0, 1);
    issue(1, 1300, 1);
    issue(0, 500, 1);
    issue(1, 1100, 1);
    issue(1, 0, 1);
    idle(3);
    // Clamped end level: pulse never ends until hysteresis is restored
    hyst_v = 2000;
    issue(1, 1200, 1);
    for (int i = 0; i < 20; i++) issue(1, 0, 1);
    hyst_v = 100;
    issue(1, 0, 1);
    idle(3);
    // Reset mid-pulse with a held record and a non-zero drop count
    foreach (s5[i]) issue(1, s5[i], 0);
    reset_mid_cycle();
    issue(1, 0, 1);
    issue(1, 500, 1);
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ((c % 50) == 0) begin
        thr_v  = $urandom_range(300, 3000);
        hyst_v = ($urandom_range(0, 9) == 0) ? thr_v + 10 : $urandom_range(0, 700);
      end
      issue($urandom_range(0, 9) < 8, $urandom_range(0, 4000), $urandom_range(0, 9) < 7);
    end
    hyst_v = 0;
    for (int i = 0; i < 4; i++) issue(1, 0, 1);
    issue(0, 0, 1);
    issue(0, 0, 1);
    @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
